// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

    // Sequencer states; FIX is only reachable when signed support is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int MULDIV_N = 32;

    // Step-counter width for an n-step operation (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(MULDIV_N);

endpackage

// File: rtl/muldiv_step.sv
// Shared N-bit add/sub step for muldiv_seq.
// res = {carry, sum} for add, {borrow, difference} for sub.
module muldiv_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N:0]   res
);

    logic [N-1:0] y_eff;
    logic [N:0]   sum;

    // Conditionally invert the second operand so one adder serves both add and sub.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_inv
            assign y_eff[gi] = y[gi] ^ sub;
        end
    endgenerate

    // x + ~y + 1 for subtraction; the carry out is the inverse of the borrow.
    always_comb begin
        sum = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, sub};
        res = {sum[N] ^ sub, sum[N-1:0]};
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MIPS HI/LO multiply/divide sequencer: one add/sub step per cycle, N cycles.
// Optional feature macro: MULDIV_SIGNED_EN enables signed MULT/DIV (extra FIX cycle).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [N-1:0]   hi_reg, hi_next;
    logic [N-1:0]   lo_reg, lo_next;
    logic [N-1:0]   b_reg, b_next;
    logic           op_reg, op_next;
    logic           div_zero_reg, div_zero_next;

    logic [N-1:0]   a_mag, b_mag;
    logic [N-1:0]   div_shift;
    logic [N-1:0]   step_x;
    logic [N:0]     step_res;
    logic [N:0]     mul_sum;
    logic           div_ok;
    logic [N-1:0]   step_hi, step_lo;

`ifdef MULDIV_SIGNED_EN
    localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};
    logic           sgn_reg, sgn_next;
    logic           neg_lo_reg, neg_lo_next;
    logic           neg_hi_reg, neg_hi_next;
    logic           a_neg, b_neg;
    logic [2*N-1:0] prod_neg;

    // Signed requests run on magnitudes; signs are fixed up after the last step.
    always_comb begin
        a_neg    = is_signed & a[N-1];
        b_neg    = is_signed & b[N-1];
        a_mag    = a_neg ? (~a + ONE_N) : a;
        b_mag    = b_neg ? (~b + ONE_N) : b;
        prod_neg = ~{hi_reg, lo_reg} + ONE_2N;
    end
`else
    logic is_signed_unused;
    assign is_signed_unused = is_signed;

    // Unsigned-only build: operands pass straight through.
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    muldiv_step #(.N(N)) u_step (
        .x   (step_x),
        .y   (b_reg),
        .sub (op_reg),
        .res (step_res)
    );

    // One multiply (shift-add) or divide (restoring) iteration on the current hi/lo.
    always_comb begin
        div_shift = {hi_reg[N-2:0], lo_reg[N-1]};
        step_x    = (op_reg == OP_DIV) ? div_shift : hi_reg;
        mul_sum   = lo_reg[0] ? step_res : {1'b0, hi_reg};
        // The bit shifted out of hi is the MSB of the partial remainder;
        // when set the subtraction always succeeds.
        div_ok    = ~step_res[N] | hi_reg[N-1];
        if (op_reg == OP_DIV) begin
            step_hi = div_ok ? step_res[N-1:0] : div_shift;
            step_lo = {lo_reg[N-2:0], div_ok};
        end else begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], lo_reg[N-1:1]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (cnt_reg == CNT_LAST) begin
`ifdef MULDIV_SIGNED_EN
                    state_next = sgn_reg ? FIX : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy     = (state_reg == RUN) || (state_reg == FIX);
        done     = (state_reg == DONE);
        div_zero = div_zero_reg;
        hi       = hi_reg;
        lo       = lo_reg;
    end

    // Datapath next values: load on accept, iterate in RUN, sign fix in FIX.
    always_comb begin
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        b_next        = b_reg;
        op_next       = op_reg;
        cnt_next      = cnt_reg;
        div_zero_next = div_zero_reg;
`ifdef MULDIV_SIGNED_EN
        sgn_next      = sgn_reg;
        neg_lo_next   = neg_lo_reg;
        neg_hi_next   = neg_hi_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    hi_next       = '0;
                    lo_next       = a_mag;
                    b_next        = b_mag;
                    op_next       = op;
                    cnt_next      = '0;
                    div_zero_next = 1'b0;
`ifdef MULDIV_SIGNED_EN
                    sgn_next      = is_signed;
                    neg_lo_next   = a_neg ^ b_neg;
                    neg_hi_next   = a_neg;
`endif
                end
            end
            RUN: begin
                hi_next  = step_hi;
                lo_next  = step_lo;
                cnt_next = cnt_reg + CNT_ONE;
            end
`ifdef MULDIV_SIGNED_EN
            FIX: begin
                if (op_reg == OP_MUL) begin
                    if (neg_lo_reg) {hi_next, lo_next} = prod_neg;
                end else begin
                    if (neg_lo_reg) lo_next = ~lo_reg + ONE_N;
                    if (neg_hi_reg) hi_next = ~hi_reg + ONE_N;
                end
            end
`endif
            default: ;
        endcase
        // Flag a zero divisor in the same cycle the done pulse appears.
        if ((state_reg != DONE) && (state_next == DONE)) begin
            div_zero_next = (op_reg == OP_DIV) && (b_reg == '0);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            b_reg        <= '0;
            op_reg       <= OP_MUL;
            cnt_reg      <= '0;
            div_zero_reg <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_reg      <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
`endif
        end else begin
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            b_reg        <= b_next;
            op_reg       <= op_next;
            cnt_reg      <= cnt_next;
            div_zero_reg <= div_zero_next;
`ifdef MULDIV_SIGNED_EN
            sgn_reg      <= sgn_next;
            neg_lo_reg   <= neg_lo_next;
            neg_hi_reg   <= neg_hi_next;
`endif
        end
    end

endmodule
